axi_rd_arb: RTL and testbench

- Two-requester AXI4 read-channel arbiter. Shares one AXI master read port (AR + R) between two read requesters, e.g. the instruction-fetch unit on port 0 and the load/store unit on port 1.
- Allows one outstanding transaction at a time.
- Sits between the core's AXI_MST_RD_CTRL instances and the interconnect master port.
- R beats are steered back to the requester that owns the current grant.

---
 rtl/axi_rd_arb.sv | 227 ++++++++++++++++++++++
 tb/tb_axi_rd_arb.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arb.sv
// axi_rd_arb: two-requester AXI4 read-channel arbiter.
// Shares one AXI master read port (AR + R) between requester port 0 (e.g. instruction
// fetch) and port 1 (e.g. load/store). One transaction is outstanding at a time; R beats
// are steered back to the port that owns the grant.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   axi_s0_* / axi_s1_*   requester AR inputs, AR ready, R channel (payload broadcast)
//   axi_mst_*             master AR (registered payload, constant lock/cache/qos/region)
//                         and R channel
//   arb_busy              high whenever the arbiter is not idle
//   arb_grant             port that owns the current or most recent grant
// Parameters:
//   FIXED_PRIO    0 = round-robin, 1 = fixed priority with port 0 favoured
//   STARVE_LIMIT  fixed mode: consecutive port-0 wins over a waiting port 1 before
//                 port 1 is forced through (1..15)

`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_LEN_WIDTH
`define AXI_LEN_WIDTH 8
`endif
`ifndef AXI_SIZE_WIDTH
`define AXI_SIZE_WIDTH 3
`endif
`ifndef AXI_BURST_WIDTH
`define AXI_BURST_WIDTH 2
`endif
`ifndef AXI_PROT_WIDTH
`define AXI_PROT_WIDTH 3
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_RESP_WIDTH
`define AXI_RESP_WIDTH 2
`endif
`ifndef AXI_LOCK_WIDTH
`define AXI_LOCK_WIDTH 1
`endif
`ifndef AXI_CACHE_WIDTH
`define AXI_CACHE_WIDTH 4
`endif
`ifndef AXI_QOS_WIDTH
`define AXI_QOS_WIDTH 4
`endif
`ifndef AXI_REGION_WIDTH
`define AXI_REGION_WIDTH 4
`endif

module axi_rd_arb #(
   parameter int FIXED_PRIO   = 0,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   // requester 0
   input  logic                          axi_s0_arvalid,
   output logic                          axi_s0_arready,
   input  logic [`AXI_ID_WIDTH-1:0]      axi_s0_arid,
   input  logic [`AXI_ADDR_WIDTH-1:0]    axi_s0_araddr,
   input  logic [`AXI_LEN_WIDTH-1:0]     axi_s0_arlen,
   input  logic [`AXI_SIZE_WIDTH-1:0]    axi_s0_arsize,
   input  logic [`AXI_BURST_WIDTH-1:0]   axi_s0_arburst,
   input  logic [`AXI_PROT_WIDTH-1:0]    axi_s0_arprot,
   output logic                          axi_s0_rvalid,
   input  logic                          axi_s0_rready,
   output logic [`AXI_ID_WIDTH-1:0]      axi_s0_rid,
   output logic [`AXI_DATA_WIDTH-1:0]    axi_s0_rdata,
   output logic [`AXI_RESP_WIDTH-1:0]    axi_s0_rresp,
   output logic                          axi_s0_rlast,
   // requester 1
   input  logic                          axi_s1_arvalid,
   output logic                          axi_s1_arready,
   input  logic [`AXI_ID_WIDTH-1:0]      axi_s1_arid,
   input  logic [`AXI_ADDR_WIDTH-1:0]    axi_s1_araddr,
   input  logic [`AXI_LEN_WIDTH-1:0]     axi_s1_arlen,
   input  logic [`AXI_SIZE_WIDTH-1:0]    axi_s1_arsize,
   input  logic [`AXI_BURST_WIDTH-1:0]   axi_s1_arburst,
   input  logic [`AXI_PROT_WIDTH-1:0]    axi_s1_arprot,
   output logic                          axi_s1_rvalid,
   input  logic                          axi_s1_rready,
   output logic [`AXI_ID_WIDTH-1:0]      axi_s1_rid,
   output logic [`AXI_DATA_WIDTH-1:0]    axi_s1_rdata,
   output logic [`AXI_RESP_WIDTH-1:0]    axi_s1_rresp,
   output logic                          axi_s1_rlast,
   // master port
   output logic                          axi_mst_arvalid,
   input  logic                          axi_mst_arready,
   output logic [`AXI_ID_WIDTH-1:0]      axi_mst_arid,
   output logic [`AXI_ADDR_WIDTH-1:0]    axi_mst_araddr,
   output logic [`AXI_LEN_WIDTH-1:0]     axi_mst_arlen,
   output logic [`AXI_SIZE_WIDTH-1:0]    axi_mst_arsize,
   output logic [`AXI_BURST_WIDTH-1:0]   axi_mst_arburst,
   output logic [`AXI_PROT_WIDTH-1:0]    axi_mst_arprot,
   output logic [`AXI_LOCK_WIDTH-1:0]    axi_mst_arlock,
   output logic [`AXI_CACHE_WIDTH-1:0]   axi_mst_arcache,
   output logic [`AXI_QOS_WIDTH-1:0]     axi_mst_arqos,
   output logic [`AXI_REGION_WIDTH-1:0]  axi_mst_arregion,
   input  logic                          axi_mst_rvalid,
   output logic                          axi_mst_rready,
   input  logic [`AXI_ID_WIDTH-1:0]      axi_mst_rid,
   input  logic [`AXI_DATA_WIDTH-1:0]    axi_mst_rdata,
   input  logic [`AXI_RESP_WIDTH-1:0]    axi_mst_rresp,
   input  logic                          axi_mst_rlast,
   // status
   output logic                          arb_busy,
   output logic                          arb_grant
);

   typedef enum logic [1:0] {ST_IDLE, ST_AR, ST_R} state_t;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   state_t     state, state_nx;
   logic       last_grant;
   logic       win;
   logic       grant_now;
   logic       r_done;
   logic [3:0] starve_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx        = state;
      win             = axi_s1_arvalid;
      grant_now       = 1'b0;
      r_done          = 1'b0;
      axi_s0_arready  = 1'b0;
      axi_s1_arready  = 1'b0;
      axi_s0_rvalid   = 1'b0;
      axi_s1_rvalid   = 1'b0;
      axi_mst_arvalid = 1'b0;
      axi_mst_rready  = 1'b0;

      if (axi_s0_arvalid && axi_s1_arvalid) begin
         if (FIXED_PRIO != 0) win = (starve_cnt == LIMIT);
         else                 win = ~last_grant;
      end

      case (state)
         ST_IDLE: begin
            // rst_n gating keeps arready low while reset is held with requests pending
            if (rst_n && (axi_s0_arvalid || axi_s1_arvalid)) begin
               grant_now      = 1'b1;
               axi_s0_arready = ~win;
               axi_s1_arready = win;
               state_nx       = ST_AR;
            end
         end
         ST_AR: begin
            axi_mst_arvalid = 1'b1;
            if (axi_mst_arready) state_nx = ST_R;
         end
         ST_R: begin
            axi_mst_rready = arb_grant ? axi_s1_rready : axi_s0_rready;
            axi_s0_rvalid  = ~arb_grant & axi_mst_rvalid;
            axi_s1_rvalid  = arb_grant & axi_mst_rvalid;
            r_done = axi_mst_rvalid & axi_mst_rlast &
                     (arb_grant ? axi_s1_rready : axi_s0_rready);
            if (r_done) state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         arb_grant       <= 1'b0;
         last_grant      <= 1'b1;
         starve_cnt      <= '0;
         axi_mst_arid    <= '0;
         axi_mst_araddr  <= '0;
         axi_mst_arlen   <= '0;
         axi_mst_arsize  <= '0;
         axi_mst_arburst <= '0;
         axi_mst_arprot  <= '0;
      end else begin
         if (grant_now) begin
            arb_grant <= win;
            if (win) begin
               axi_mst_arid    <= axi_s1_arid;
               axi_mst_araddr  <= axi_s1_araddr;
               axi_mst_arlen   <= axi_s1_arlen;
               axi_mst_arsize  <= axi_s1_arsize;
               axi_mst_arburst <= axi_s1_arburst;
               axi_mst_arprot  <= axi_s1_arprot;
               starve_cnt      <= '0;
            end else begin
               axi_mst_arid    <= axi_s0_arid;
               axi_mst_araddr  <= axi_s0_araddr;
               axi_mst_arlen   <= axi_s0_arlen;
               axi_mst_arsize  <= axi_s0_arsize;
               axi_mst_arburst <= axi_s0_arburst;
               axi_mst_arprot  <= axi_s0_arprot;
               // counts port-0 wins only while port 1 was kept waiting
               if (axi_s1_arvalid && (starve_cnt != LIMIT))
                  starve_cnt <= starve_cnt + 4'd1;
            end
         end
         if (r_done) last_grant <= arb_grant;
      end
   end

   assign axi_mst_arlock   = '0;
   assign axi_mst_arcache  = '0;
   assign axi_mst_arqos    = '0;
   assign axi_mst_arregion = '0;

   assign axi_s0_rid   = axi_mst_rid;
   assign axi_s0_rdata = axi_mst_rdata;
   assign axi_s0_rresp = axi_mst_rresp;
   assign axi_s0_rlast = axi_mst_rlast;
   assign axi_s1_rid   = axi_mst_rid;
   assign axi_s1_rdata = axi_mst_rdata;
   assign axi_s1_rresp = axi_mst_rresp;
   assign axi_s1_rlast = axi_mst_rlast;

   assign arb_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_axi_rd_arb.sv
// Testbench for axi_rd_arb: a round-robin instance and a fixed-priority instance
// (STARVE_LIMIT=2) share all inputs and run in lockstep.

`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_LEN_WIDTH
`define AXI_LEN_WIDTH 8
`endif
`ifndef AXI_SIZE_WIDTH
`define AXI_SIZE_WIDTH 3
`endif
`ifndef AXI_BURST_WIDTH
`define AXI_BURST_WIDTH 2
`endif
`ifndef AXI_PROT_WIDTH
`define AXI_PROT_WIDTH 3
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_RESP_WIDTH
`define AXI_RESP_WIDTH 2
`endif
`ifndef AXI_LOCK_WIDTH
`define AXI_LOCK_WIDTH 1
`endif
`ifndef AXI_CACHE_WIDTH
`define AXI_CACHE_WIDTH 4
`endif
`ifndef AXI_QOS_WIDTH
`define AXI_QOS_WIDTH 4
`endif
`ifndef AXI_REGION_WIDTH
`define AXI_REGION_WIDTH 4
`endif

module tb_axi_rd_arb;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // shared stimulus
   logic s0_arvalid, s1_arvalid, s0_rready, s1_rready;
   logic [`AXI_ID_WIDTH-1:0]    s0_arid, s1_arid;
   logic [`AXI_ADDR_WIDTH-1:0]  s0_araddr, s1_araddr;
   logic [`AXI_LEN_WIDTH-1:0]   s0_arlen, s1_arlen;
   logic [`AXI_SIZE_WIDTH-1:0]  s0_arsize, s1_arsize;
   logic [`AXI_BURST_WIDTH-1:0] s0_arburst, s1_arburst;
   logic [`AXI_PROT_WIDTH-1:0]  s0_arprot, s1_arprot;
   logic mst_arready, mst_rvalid, mst_rlast;
   logic [`AXI_ID_WIDTH-1:0]    mst_rid;
   logic [`AXI_DATA_WIDTH-1:0]  mst_rdata;
   logic [`AXI_RESP_WIDTH-1:0]  mst_rresp;

   // round-robin instance outputs
   logic rr_s0_arready, rr_s1_arready, rr_s0_rvalid, rr_s1_rvalid, rr_s0_rlast, rr_s1_rlast;
   logic [`AXI_ID_WIDTH-1:0]     rr_s0_rid, rr_s1_rid, rr_mst_arid;
   logic [`AXI_DATA_WIDTH-1:0]   rr_s0_rdata, rr_s1_rdata;
   logic [`AXI_RESP_WIDTH-1:0]   rr_s0_rresp, rr_s1_rresp;
   logic rr_mst_arvalid, rr_mst_rready, rr_arb_busy, rr_arb_grant;
   logic [`AXI_ADDR_WIDTH-1:0]   rr_mst_araddr;
   logic [`AXI_LEN_WIDTH-1:0]    rr_mst_arlen;
   logic [`AXI_SIZE_WIDTH-1:0]   rr_mst_arsize;
   logic [`AXI_BURST_WIDTH-1:0]  rr_mst_arburst;
   logic [`AXI_PROT_WIDTH-1:0]   rr_mst_arprot;
   logic [`AXI_LOCK_WIDTH-1:0]   rr_mst_arlock;
   logic [`AXI_CACHE_WIDTH-1:0]  rr_mst_arcache;
   logic [`AXI_QOS_WIDTH-1:0]    rr_mst_arqos;
   logic [`AXI_REGION_WIDTH-1:0] rr_mst_arregion;

   // fixed-priority instance outputs
   logic fx_s0_arready, fx_s1_arready, fx_s0_rvalid, fx_s1_rvalid, fx_s0_rlast, fx_s1_rlast;
   logic [`AXI_ID_WIDTH-1:0]     fx_s0_rid, fx_s1_rid, fx_mst_arid;
   logic [`AXI_DATA_WIDTH-1:0]   fx_s0_rdata, fx_s1_rdata;
   logic [`AXI_RESP_WIDTH-1:0]   fx_s0_rresp, fx_s1_rresp;
   logic fx_mst_arvalid, fx_mst_rready, fx_arb_busy, fx_arb_grant;
   logic [`AXI_ADDR_WIDTH-1:0]   fx_mst_araddr;
   logic [`AXI_LEN_WIDTH-1:0]    fx_mst_arlen;
   logic [`AXI_SIZE_WIDTH-1:0]   fx_mst_arsize;
   logic [`AXI_BURST_WIDTH-1:0]  fx_mst_arburst;
   logic [`AXI_PROT_WIDTH-1:0]   fx_mst_arprot;
   logic [`AXI_LOCK_WIDTH-1:0]   fx_mst_arlock;
   logic [`AXI_CACHE_WIDTH-1:0]  fx_mst_arcache;
   logic [`AXI_QOS_WIDTH-1:0]    fx_mst_arqos;
   logic [`AXI_REGION_WIDTH-1:0] fx_mst_arregion;

   axi_rd_arb #(.FIXED_PRIO(0), .STARVE_LIMIT(4)) dut_rr (
      .clk(clk), .rst_n(rst_n),
      .axi_s0_arvalid(s0_arvalid), .axi_s0_arready(rr_s0_arready), .axi_s0_arid(s0_arid),
      .axi_s0_araddr(s0_araddr), .axi_s0_arlen(s0_arlen), .axi_s0_arsize(s0_arsize),
      .axi_s0_arburst(s0_arburst), .axi_s0_arprot(s0_arprot), .axi_s0_rvalid(rr_s0_rvalid),
      .axi_s0_rready(s0_rready), .axi_s0_rid(rr_s0_rid), .axi_s0_rdata(rr_s0_rdata),
      .axi_s0_rresp(rr_s0_rresp), .axi_s0_rlast(rr_s0_rlast),
      .axi_s1_arvalid(s1_arvalid), .axi_s1_arready(rr_s1_arready), .axi_s1_arid(s1_arid),
      .axi_s1_araddr(s1_araddr), .axi_s1_arlen(s1_arlen), .axi_s1_arsize(s1_arsize),
      .axi_s1_arburst(s1_arburst), .axi_s1_arprot(s1_arprot), .axi_s1_rvalid(rr_s1_rvalid),
      .axi_s1_rready(s1_rready), .axi_s1_rid(rr_s1_rid), .axi_s1_rdata(rr_s1_rdata),
      .axi_s1_rresp(rr_s1_rresp), .axi_s1_rlast(rr_s1_rlast),
      .axi_mst_arvalid(rr_mst_arvalid), .axi_mst_arready(mst_arready), .axi_mst_arid(rr_mst_arid),
      .axi_mst_araddr(rr_mst_araddr), .axi_mst_arlen(rr_mst_arlen), .axi_mst_arsize(rr_mst_arsize),
      .axi_mst_arburst(rr_mst_arburst), .axi_mst_arprot(rr_mst_arprot),
      .axi_mst_arlock(rr_mst_arlock), .axi_mst_arcache(rr_mst_arcache),
      .axi_mst_arqos(rr_mst_arqos), .axi_mst_arregion(rr_mst_arregion),
      .axi_mst_rvalid(mst_rvalid), .axi_mst_rready(rr_mst_rready), .axi_mst_rid(mst_rid),
      .axi_mst_rdata(mst_rdata), .axi_mst_rresp(mst_rresp), .axi_mst_rlast(mst_rlast),
      .arb_busy(rr_arb_busy), .arb_grant(rr_arb_grant)
   );

   axi_rd_arb #(.FIXED_PRIO(1), .STARVE_LIMIT(2)) dut_fx (
      .clk(clk), .rst_n(rst_n),
      .axi_s0_arvalid(s0_arvalid), .axi_s0_arready(fx_s0_arready), .axi_s0_arid(s0_arid),
      .axi_s0_araddr(s0_araddr), .axi_s0_arlen(s0_arlen), .axi_s0_arsize(s0_arsize),
      .axi_s0_arburst(s0_arburst), .axi_s0_arprot(s0_arprot), .axi_s0_rvalid(fx_s0_rvalid),
      .axi_s0_rready(s0_rready), .axi_s0_rid(fx_s0_rid), .axi_s0_rdata(fx_s0_rdata),
      .axi_s0_rresp(fx_s0_rresp), .axi_s0_rlast(fx_s0_rlast),
      .axi_s1_arvalid(s1_arvalid), .axi_s1_arready(fx_s1_arready), .axi_s1_arid(s1_arid),
      .axi_s1_araddr(s1_araddr), .axi_s1_arlen(s1_arlen), .axi_s1_arsize(s1_arsize),
      .axi_s1_arburst(s1_arburst), .axi_s1_arprot(s1_arprot), .axi_s1_rvalid(fx_s1_rvalid),
      .axi_s1_rready(s1_rready), .axi_s1_rid(fx_s1_rid), .axi_s1_rdata(fx_s1_rdata),
      .axi_s1_rresp(fx_s1_rresp), .axi_s1_rlast(fx_s1_rlast),
      .axi_mst_arvalid(fx_mst_arvalid), .axi_mst_arready(mst_arready), .axi_mst_arid(fx_mst_arid),
      .axi_mst_araddr(fx_mst_araddr), .axi_mst_arlen(fx_mst_arlen), .axi_mst_arsize(fx_mst_arsize),
      .axi_mst_arburst(fx_mst_arburst), .axi_mst_arprot(fx_mst_arprot),
      .axi_mst_arlock(fx_mst_arlock), .axi_mst_arcache(fx_mst_arcache),
      .axi_mst_arqos(fx_mst_arqos), .axi_mst_arregion(fx_mst_arregion),
      .axi_mst_rvalid(mst_rvalid), .axi_mst_rready(fx_mst_rready), .axi_mst_rid(mst_rid),
      .axi_mst_rdata(mst_rdata), .axi_mst_rresp(mst_rresp), .axi_mst_rlast(mst_rlast),
      .arb_busy(fx_arb_busy), .arb_grant(fx_arb_grant)
   );

   typedef struct packed {
      logic [`AXI_ADDR_WIDTH-1:0] addr;
      logic [`AXI_LEN_WIDTH-1:0]  len;
      logic [`AXI_ID_WIDTH-1:0]   id;
   } ar_exp_t;

   typedef struct packed {
      logic [`AXI_DATA_WIDTH-1:0] data;
      logic                       last;
   } r_exp_t;

   ar_exp_t ar_q[$];
   r_exp_t  r_q[$];

   int pass_cnt = 0;
   int total    = 0;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
      total++;
      assert (obs === exp_v) pass_cnt++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
   endtask

   // compare the master AR payload of the round-robin instance against the oldest expectation
   task automatic pop_ar(input string tag);
      ar_exp_t e;
      chk({tag, "_qdepth"}, 256'(ar_q.size()), 256'd1);
      if (ar_q.size() > 0) begin
         e = ar_q.pop_front();
         chk(tag, {rr_mst_araddr, rr_mst_arlen, rr_mst_arid}, e);
      end
   endtask

   task automatic pop_r(input string tag, input logic [`AXI_DATA_WIDTH-1:0] data, input logic last);
      r_exp_t e;
      if (r_q.size() == 0) chk({tag, "_qempty"}, 256'(r_q.size()), 256'd1);
      else begin
         e = r_q.pop_front();
         chk(tag, {data, last}, e);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic last_m;
   int   cnt_m;
   logic exp_rr, exp_fx;
   int   n;
   int   beat;

   initial begin
      // ---------------- reset state, requests pending during reset ----------------
      rst_n = 1'b0;
      s0_arvalid = 1'b1; s1_arvalid = 1'b1; s0_rready = 1'b1; s1_rready = 1'b1;
      s0_arid = 4'd1; s0_araddr = 32'h1000; s0_arlen = '0; s0_arsize = 3'd2; s0_arburst = 2'd1; s0_arprot = '0;
      s1_arid = 4'd2; s1_araddr = 32'h2000; s1_arlen = '0; s1_arsize = 3'd2; s1_arburst = 2'd1; s1_arprot = '0;
      mst_arready = 1'b0; mst_rvalid = 1'b0; mst_rlast = 1'b0;
      mst_rid = '0; mst_rdata = '0; mst_rresp = '0;
      repeat (2) @(negedge clk);
      chk("reset_rr_all", {rr_s0_arready, rr_s1_arready, rr_s0_rvalid, rr_s1_rvalid, rr_s0_rlast,
          rr_s1_rlast, rr_s0_rid, rr_s1_rid, rr_mst_arid, rr_s0_rdata, rr_s1_rdata, rr_s0_rresp,
          rr_s1_rresp, rr_mst_arvalid, rr_mst_rready, rr_arb_busy, rr_arb_grant, rr_mst_araddr,
          rr_mst_arlen, rr_mst_arsize, rr_mst_arburst, rr_mst_arprot, rr_mst_arlock,
          rr_mst_arcache, rr_mst_arqos, rr_mst_arregion}, '0);
      chk("reset_fx_all", {fx_s0_arready, fx_s1_arready, fx_s0_rvalid, fx_s1_rvalid, fx_s0_rlast,
          fx_s1_rlast, fx_s0_rid, fx_s1_rid, fx_mst_arid, fx_s0_rdata, fx_s1_rdata, fx_s0_rresp,
          fx_s1_rresp, fx_mst_arvalid, fx_mst_rready, fx_arb_busy, fx_arb_grant, fx_mst_araddr,
          fx_mst_arlen, fx_mst_arsize, fx_mst_arburst, fx_mst_arprot, fx_mst_arlock,
          fx_mst_arcache, fx_mst_arqos, fx_mst_arregion}, '0);

      // ---------------- continuous tie: six transactions ----------------
      // master accepts AR at once and answers with a single-beat response, so each
      // transaction is IDLE, AR, R
      mst_arready = 1'b1; mst_rvalid = 1'b1; mst_rlast = 1'b1; mst_rdata = 32'h5555_0000;
      last_m = 1'b1; cnt_m = 0;
      @(posedge clk); #1 rst_n = 1'b1;
      for (int t = 0; t < 6; t++) begin
         n = 0;
         do begin @(negedge clk); n++; end
         while (!(rr_s0_arready || rr_s1_arready) && n < 10);
         chk("tie_grant_seen", rr_s0_arready | rr_s1_arready, 1'b1);
         exp_rr = ~last_m; last_m = exp_rr;
         exp_fx = (cnt_m == 2);
         if (exp_fx) cnt_m = 0; else cnt_m = cnt_m + 1;
         chk("tie_rr_arready", {rr_s1_arready, rr_s0_arready}, exp_rr ? 2'b10 : 2'b01);
         chk("tie_fx_arready", {fx_s1_arready, fx_s0_arready}, exp_fx ? 2'b10 : 2'b01);
         ar_q.push_back(exp_rr ? ar_exp_t'({32'h2000, 8'd0, 4'd2}) : ar_exp_t'({32'h1000, 8'd0, 4'd1}));
         @(posedge clk); #1;
         if (t == 5) begin s0_arvalid = 1'b0; s1_arvalid = 1'b0; end
         @(negedge clk);
         chk("tie_mst_arvalid", rr_mst_arvalid, 1'b1);
         pop_ar("tie_ar_payload");
         chk("tie_rr_grant", rr_arb_grant, exp_rr);
         chk("tie_fx_grant", fx_arb_grant, exp_fx);
         @(negedge clk);
         chk("tie_rvalid_steer", {rr_s1_rvalid, rr_s0_rvalid}, exp_rr ? 2'b10 : 2'b01);
      end
      @(negedge clk);
      chk("tie_idle_bubble", {rr_arb_busy, rr_s0_arready, rr_s1_arready}, 3'b000);
      @(posedge clk); #1 mst_rvalid = 1'b0; mst_rlast = 1'b0;

      // ---------------- AR backpressure and 4-beat burst on port 1 ----------------
      s1_arvalid = 1'b1; s1_araddr = 32'h3000; s1_arlen = 8'd3; s1_arid = 4'd5;
      s1_arsize = 3'd2; s1_arburst = 2'd1; s1_arprot = 3'd2; mst_arready = 1'b0; s1_rready = 1'b0;
      ar_q.push_back(ar_exp_t'({32'h3000, 8'd3, 4'd5}));
      @(negedge clk);
      chk("bp_arready", {rr_s1_arready, rr_s0_arready}, 2'b10);
      @(posedge clk); #1 s1_arvalid = 1'b0; s1_araddr = 32'hFFFF_FFFF; s1_arlen = 8'd0; s1_arid = 4'd0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("bp_stall_payload", {rr_mst_arvalid, rr_mst_araddr, rr_mst_arlen, rr_mst_arid,
             rr_mst_arsize, rr_mst_arburst, rr_mst_arprot},
             {1'b1, 32'h3000, 8'd3, 4'd5, 3'd2, 2'd1, 3'd2});
      end
      @(posedge clk); #1 mst_arready = 1'b1;
      @(negedge clk);
      chk("bp_ar_handshake", rr_mst_arvalid, 1'b1);
      pop_ar("bp_ar_payload");
      for (int b = 0; b < 4; b++)
         r_q.push_back(r_exp_t'({32'hB000_0000 + 32'(b), b == 3}));
      @(posedge clk); #1 mst_arready = 1'b0;
      beat = 0;
      for (int c = 0; c < 20 && beat < 4; c++) begin
         if (c > 0) begin @(posedge clk); #1; end
         mst_rvalid = 1'b1; mst_rid = 4'd5; mst_rdata = 32'hB000_0000 + 32'(beat);
         mst_rlast = (beat == 3); s1_rready = c[0];
         @(negedge clk);
         chk("bp_busy", rr_arb_busy, 1'b1);
         chk("bp_rvalid", {rr_s1_rvalid, rr_s0_rvalid}, 2'b10);
         chk("bp_rready_pass", rr_mst_rready, s1_rready);
         if (rr_mst_rready) begin
            pop_r("bp_beat", rr_s1_rdata, rr_s1_rlast);
            beat++;
         end
      end
      chk("bp_beat_count", beat, 4);
      @(posedge clk); #1 mst_rvalid = 1'b0; mst_rlast = 1'b0; s1_rready = 1'b1;
      @(negedge clk);
      chk("bp_back_idle", rr_arb_busy, 1'b0);

      // ---------------- stray master data while idle ----------------
      @(posedge clk); #1 mst_rvalid = 1'b1; mst_rlast = 1'b1; mst_rdata = 32'h1234_5678;
      @(negedge clk);
      chk("stray_blocked", {rr_mst_rready, rr_s0_rvalid, rr_s1_rvalid, rr_arb_busy}, 4'b0000);
      @(posedge clk); #1 mst_rvalid = 1'b0; mst_rlast = 1'b0;

      // ---------------- single request on port 0 ----------------
      s0_arvalid = 1'b1; s0_araddr = 32'h100; s0_arlen = 8'd0; s0_arid = 4'd3;
      mst_arready = 1'b1; s0_rready = 1'b1;
      ar_q.push_back(ar_exp_t'({32'h100, 8'd0, 4'd3}));
      @(negedge clk);
      chk("single_arready", {rr_s1_arready, rr_s0_arready, rr_mst_arvalid, rr_mst_rready}, 4'b0100);
      @(posedge clk); #1 s0_arvalid = 1'b0;
      @(negedge clk);
      chk("single_mst_arvalid", rr_mst_arvalid, 1'b1);
      pop_ar("single_ar_payload");
      chk("single_grant", rr_arb_grant, 1'b0);
      @(posedge clk); #1 mst_rvalid = 1'b1; mst_rlast = 1'b1; mst_rdata = 32'hDEAD_BEEF; mst_rresp = 2'b10;
      r_q.push_back(r_exp_t'({32'hDEAD_BEEF, 1'b1}));
      @(negedge clk);
      chk("single_rvalid", {rr_s1_rvalid, rr_s0_rvalid, rr_mst_rready}, 3'b011);
      pop_r("single_beat", rr_s0_rdata, rr_s0_rlast);
      chk("single_rresp", rr_s0_rresp, 2'b10);
      @(posedge clk); #1 mst_rvalid = 1'b0; mst_rlast = 1'b0; mst_rresp = '0;
      @(negedge clk);
      chk("single_idle", rr_arb_busy, 1'b0);

      // ---------------- reset during beat 2 of a 4-beat burst ----------------
      @(posedge clk); #1 s0_arvalid = 1'b1; s0_araddr = 32'h400; s0_arlen = 8'd3;
      @(negedge clk);
      chk("mrst_arready", rr_s0_arready, 1'b1);
      @(posedge clk); #1 s0_arvalid = 1'b0;
      @(negedge clk);
      chk("mrst_mst_arvalid", rr_mst_arvalid, 1'b1);
      @(posedge clk); #1 mst_rvalid = 1'b1; mst_rdata = 32'hC000_0000;
      @(negedge clk);
      chk("mrst_beat1", {rr_s0_rvalid, rr_mst_rready, rr_arb_busy}, 3'b111);
      @(posedge clk); #1 mst_rdata = 32'hC000_0001; s0_arvalid = 1'b1; s1_arvalid = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      chk("mrst_outputs", {rr_s0_arready, rr_s1_arready, rr_s0_rvalid, rr_s1_rvalid,
          rr_mst_arvalid, rr_mst_rready, rr_arb_busy, rr_arb_grant, rr_mst_araddr, rr_mst_arlen},
          '0);
      @(posedge clk); #1 rst_n = 1'b1; mst_rvalid = 1'b0;
      @(negedge clk);
      chk("mrst_tie_port0", {rr_s1_arready, rr_s0_arready}, 2'b01);
      @(posedge clk); #1 s0_arvalid = 1'b0; s1_arvalid = 1'b0;
      @(negedge clk);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
